// File: rtl/draw_rect_fill_if.sv
`default_nettype none
// ============================================================================
//  Module   : draw_rect_fill_if
//  Purpose  : Request / plot bundle between a rectangle requester (master)
//             and the draw_rect_fill raster filler (slave).
//  Signals  : start, rect_x/y/w/h, rect_colour, rect_alt, plot_ready  (m->s)
//             drawing, x, y, colour, plot, finished                  (s->m)
//  Revision : 1.0  initial release
// ============================================================================
interface draw_rect_fill_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [X_W-1:0]      rect_x;
    logic [Y_W-1:0]      rect_y;
    logic [X_W-1:0]      rect_w;
    logic [Y_W-1:0]      rect_h;
    logic [COLOUR_W-1:0] rect_colour;
    logic [COLOUR_W-1:0] rect_alt;
    logic                plot_ready;
    logic                drawing;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                finished;

    modport master (
        output start, rect_x, rect_y, rect_w, rect_h, rect_colour, rect_alt, plot_ready,
        input  drawing, x, y, colour, plot, finished
    );

    modport slave (
        input  start, rect_x, rect_y, rect_w, rect_h, rect_colour, rect_alt, plot_ready,
        output drawing, x, y, colour, plot, finished
    );
endinterface
`default_nettype wire

// File: rtl/draw_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module   : draw_rect_fill
//  Purpose  : Streams one (x,y,colour) plot per accepted pixel of a requested
//             rectangle, row-major, clipped to the screen, with a
//             plot/plot_ready backpressure handshake.
//  Ports    : clock_i  - rising-edge clock
//             reset_i  - synchronous active-high reset
//             bus      - draw_rect_fill_if.slave (request in, plot stream out)
//  Options  : RECT_CHECKER_EN - checkerboard of rect_colour / rect_alt with
//             cells of 2**CHECK_SHIFT pixels in absolute screen coordinates.
//  Revision : 1.0  initial release
// ============================================================================
module draw_rect_fill #(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOUR_W    = 3,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int CHECK_SHIFT = 2
) (
    input  wire logic        clock_i,
    input  wire logic        reset_i,
    draw_rect_fill_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Screen limits widened by one bit so they compare against unwrapped sums.
    localparam logic [X_W:0] SCREEN_W_C = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCREEN_H_C = (Y_W+1)'(SCREEN_H);

    state_t              state_q;
    logic [X_W-1:0]      rect_x_q;
    logic [Y_W-1:0]      rect_y_q;
    logic [X_W-1:0]      rect_w_q;
    logic [Y_W-1:0]      rect_h_q;
    logic [COLOUR_W-1:0] col_q;
    logic [X_W:0]        x_end_q;
    logic [Y_W:0]        y_end_q;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q;
    logic                drawing_q;
    logic                finished_q;

    logic [X_W:0]        x_sum_d;
    logic [Y_W:0]        y_sum_d;
    logic [X_W:0]        x_end_d;
    logic [Y_W:0]        y_end_d;
    logic                empty_d;
    logic                x_last_d;
    logic                y_last_d;
    logic [X_W-1:0]      x_next_d;
    logic [Y_W-1:0]      y_next_d;
    logic [COLOUR_W-1:0] colour_first_d;
    logic [COLOUR_W-1:0] colour_next_d;

    // Exclusive end coordinates, clipped to the screen.
    assign x_sum_d  = {1'b0, rect_x_q} + {1'b0, rect_w_q};
    assign y_sum_d  = {1'b0, rect_y_q} + {1'b0, rect_h_q};
    assign x_end_d  = (x_sum_d > SCREEN_W_C) ? SCREEN_W_C : x_sum_d;
    assign y_end_d  = (y_sum_d > SCREEN_H_C) ? SCREEN_H_C : y_sum_d;
    assign empty_d  = (rect_w_q == '0) || (rect_h_q == '0) ||
                      ({1'b0, rect_x_q} >= SCREEN_W_C) || ({1'b0, rect_y_q} >= SCREEN_H_C);

    // Row-major walk: wrap x back to the left edge at the end of each row.
    assign x_last_d = (({1'b0, x_q} + 1'b1) == x_end_q);
    assign y_last_d = (({1'b0, y_q} + 1'b1) == y_end_q);
    assign x_next_d = x_last_d ? rect_x_q : x_q + 1'b1;
    assign y_next_d = x_last_d ? y_q + 1'b1 : y_q;

`ifdef RECT_CHECKER_EN
    logic [COLOUR_W-1:0] alt_q;

    function automatic logic [COLOUR_W-1:0] pix_colour(
        input logic [X_W-1:0]      px,
        input logic [Y_W-1:0]      py,
        input logic [COLOUR_W-1:0] c,
        input logic [COLOUR_W-1:0] a
    );
        logic [X_W-1:0] cx;
        logic [Y_W-1:0] cy;
        cx = px >> CHECK_SHIFT;
        cy = py >> CHECK_SHIFT;
        return (cx[0] ^ cy[0]) ? a : c;
    endfunction

    assign colour_first_d = pix_colour(rect_x_q, rect_y_q, col_q, alt_q);
    assign colour_next_d  = pix_colour(x_next_d, y_next_d, col_q, alt_q);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            alt_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            alt_q <= bus.rect_alt;
        end
    end
`else
    assign colour_first_d = col_q;
    assign colour_next_d  = col_q;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            rect_x_q   <= '0;
            rect_y_q   <= '0;
            rect_w_q   <= '0;
            rect_h_q   <= '0;
            col_q      <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            drawing_q  <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    finished_q <= 1'b0;
                    if (bus.start) begin
                        rect_x_q  <= bus.rect_x;
                        rect_y_q  <= bus.rect_y;
                        rect_w_q  <= bus.rect_w;
                        rect_h_q  <= bus.rect_h;
                        col_q     <= bus.rect_colour;
                        drawing_q <= 1'b1;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    x_end_q <= x_end_d;
                    y_end_q <= y_end_d;
                    if (empty_d) begin
                        drawing_q  <= 1'b0;
                        finished_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        x_q      <= rect_x_q;
                        y_q      <= rect_y_q;
                        colour_q <= colour_first_d;
                        plot_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Without plot_ready everything holds.
                    if (bus.plot_ready) begin
                        x_q <= x_next_d;
                        if (x_last_d && y_last_d) begin
                            plot_q     <= 1'b0;
                            drawing_q  <= 1'b0;
                            finished_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            y_q      <= y_next_d;
                            colour_q <= colour_next_d;
                        end
                    end
                end
                S_DONE: begin
                    finished_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.drawing  = drawing_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.colour   = colour_q;
    assign bus.plot     = plot_q;
    assign bus.finished = finished_q;

endmodule
`default_nettype wire
